dt_res_stream: RTL and testbench

//  Downstream of the distance-transform stage. On start (DT done), reads the 128x128 8-bit

---
 rtl/dt_pkg.sv | 37 +++
 rtl/dt_skid_fifo.sv | 70 +++++++
 rtl/dt_res_stream.sv | 169 ++++++++++++++++
 tb/tb_dt_res_stream.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// ---------------------------------------------------------------------------
// dt_pkg
// Shared definitions for the distance-map result streamer.
//   IMG_W / ADDR_W / DATA_W : image geometry and RAM/pixel widths
//   PIX_COUNT / LAST_ADDR   : frame size and final raster address
//   dt_state_t              : streamer control states
//   dt_beat_t               : one FIFO entry {last, data}
//   max_u                   : unsigned maximum helper for the statistics path
// Optional feature macro used by dt_res_stream: DT_STREAM_STATS_EN
// ---------------------------------------------------------------------------
package dt_pkg;

    localparam int IMG_W     = 128;
    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 8;
    localparam int PIX_COUNT = IMG_W * IMG_W;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } dt_state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } dt_beat_t;

    function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dt_skid_fifo.sv
// ---------------------------------------------------------------------------
// dt_skid_fifo
// Two-entry FIFO holding {last, data} beats between the result RAM and the
// output stream. Push and pop may happen in the same cycle; a push into a
// full FIFO is only accepted when a pop frees a slot in that same cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write push_beat this cycle
//   push_beat  : beat to store
//   pop        : remove the head beat this cycle
//   head       : current head beat
//   count      : number of stored beats (0..2)
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module dt_skid_fifo
    import dt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  dt_beat_t   push_beat,
    input  logic       pop,
    output dt_beat_t   head,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);

    dt_beat_t slot0;
    dt_beat_t slot1;
    logic     wr_ptr;
    logic     rd_ptr;
    logic     do_push;
    logic     do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = rd_ptr ? slot1 : slot0;

    // Storage and pointers; slots are cleared on reset so the head reads 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot0  <= '0;
            slot1  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                if (wr_ptr) begin
                    slot1 <= push_beat;
                end else begin
                    slot0 <= push_beat;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dt_res_stream.sv
// ---------------------------------------------------------------------------
// dt_res_stream
// After the distance transform finishes, reads the IMG_W x IMG_W distance map
// from the result RAM in raster order and streams it on a valid/ready port.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   start               : one-cycle pulse that begins a full-frame readout
//   res_rd, res_addr    : RAM read request (data returns one cycle later)
//   res_di              : RAM read data
//   out_valid/out_ready : stream handshake, beat transfers on valid & ready
//   out_data, out_last  : pixel value, marker on the final raster pixel
//   busy                : frame in progress
//   finish              : one-cycle pulse after the final beat is accepted
//   max_dist, fg_count  : frame maximum and nonzero-pixel count
// Optional feature: define DT_STREAM_STATS_EN to build the statistics logic;
// without it max_dist and fg_count are tied to zero.
// ---------------------------------------------------------------------------
module dt_res_stream
    import dt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              res_rd,
    output logic [ADDR_W-1:0] res_addr,
    input  logic [DATA_W-1:0] res_di,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              finish,
    output logic [DATA_W-1:0] max_dist,
    output logic [ADDR_W:0]   fg_count
);

    dt_state_t   state;
    dt_state_t   state_nxt;
    logic [ADDR_W-1:0] addr;
    logic        inflight;
    logic        inflight_last;
    logic        start_accept;
    logic        pop;
    logic [2:0]  pending;
    dt_beat_t    push_beat;
    dt_beat_t    fifo_head;
    logic [1:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;

    assign start_accept = (state == S_IDLE) && start;
    assign out_valid    = !fifo_empty;
    assign pop          = out_valid && out_ready;
    assign out_data     = fifo_head.data;
    assign out_last     = fifo_head.last;
    assign res_addr     = addr;
    assign push_beat    = '{last: inflight_last, data: res_di};

    // Slots that will still be occupied after this cycle: stored beats plus
    // the read in flight, minus the beat leaving now. Counting the departing
    // beat as free is what lets the stream sustain one beat per cycle.
    assign pending = 3'(fifo_count) + 3'(inflight) - 3'(pop);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Start is only honoured in IDLE, so pulses while busy
    // or in the DONE cycle fall through. DRAIN ends in the cycle the final
    // beat leaves, giving finish exactly one cycle after that handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (res_rd && (addr == LAST_ADDR)) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!inflight && (fifo_empty || ((fifo_count == 2'd1) && pop))) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state and FIFO credit.
    always_comb begin
        res_rd = 1'b0;
        busy   = 1'b0;
        finish = 1'b0;
        if (state == S_READ) begin
            res_rd = (pending < 3'd2);
        end
        busy   = (state != S_IDLE);
        finish = (state == S_DONE);
    end

    // Raster address counter; parks at LAST_ADDR once the final read issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr <= '0;
        end else if (start_accept) begin
            addr <= '0;
        end else if (res_rd && (addr != LAST_ADDR)) begin
            addr <= addr + 1'b1;
        end
    end

    // One-cycle RAM latency tracker; the last flag rides with the read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= res_rd;
            inflight_last <= res_rd && (addr == LAST_ADDR);
        end
    end

    dt_skid_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef DT_STREAM_STATS_EN
    // Frame statistics: cleared by an accepted start, updated per accepted
    // beat, and left holding their values once the frame is finished.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_dist <= '0;
            fg_count <= '0;
        end else if (start_accept) begin
            max_dist <= '0;
            fg_count <= '0;
        end else if (pop) begin
            max_dist <= max_u(max_dist, fifo_head.data);
            fg_count <= fg_count + {{ADDR_W{1'b0}}, (fifo_head.data != '0)};
        end
    end
`else
    assign max_dist = '0;
    assign fg_count = '0;
`endif

endmodule

// File: tb/tb_dt_res_stream.sv
// ---------------------------------------------------------------------------
// tb_dt_res_stream
// Randomised, self-checking bench for dt_res_stream. A frame-level model
// (expected beat index, reads issued, busy/finish timing, running statistics)
// is compared against the DUT on every falling edge; directed scenarios add
// literal expectations for latency, stalls, restart and reset behaviour.
// Honours DT_STREAM_STATS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_dt_res_stream;
    import dt_pkg::*;

    localparam int NPIX = PIX_COUNT;
`ifdef DT_STREAM_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] res_di = '0;
    logic              res_rd;
    logic [ADDR_W-1:0] res_addr;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              finish;
    logic [DATA_W-1:0] max_dist;
    logic [ADDR_W:0]   fg_count;

    logic [7:0] ram [NPIX];

    int checkCount = 0;
    int passCount  = 0;

    // Model state, written only by the compare process.
    bit busyExp    = 1'b0;
    bit finishExp  = 1'b0;
    int nextBeat   = 0;
    int issued     = 0;
    int maxExp     = 0;
    int fgExp      = 0;
    bit streamMode = 1'b0;

    dt_res_stream dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .res_rd    (res_rd),
        .res_addr  (res_addr),
        .res_di    (res_di),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .finish    (finish),
        .max_dist  (max_dist),
        .fg_count  (fg_count)
    );

    always #5 clk = ~clk;

    // Synchronous result RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (res_rd) res_di <= ram[res_addr];
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic s, input logic r);
        @(posedge clk);
        #1;
        start     = s;
        out_ready = r;
    endtask

    // Compare process: check this cycle, then advance the model.
    bit acc;
    bit startAcc;
    bit finishNext;
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("reset_outputs",
                        {res_rd, res_addr, out_valid, out_data, out_last, busy, finish, max_dist, fg_count}, 0);
            busyExp = 0; finishExp = 0; nextBeat = 0; issued = 0; maxExp = 0; fgExp = 0;
        end else begin
            acc = out_valid && out_ready;
            checkOutput("busy", busy, busyExp);
            checkOutput("finish", finish, finishExp);
            checkOutput("max_dist", max_dist, STATS_ON ? maxExp : 0);
            checkOutput("fg_count", fg_count, STATS_ON ? fgExp : 0);
            if (out_valid) begin
                if (nextBeat < NPIX) begin
                    checkOutput("out_data", out_data, ram[nextBeat]);
                    checkOutput("out_last", out_last, nextBeat == NPIX - 1);
                end else begin
                    checkOutput("extra_beat", nextBeat, NPIX - 1);
                end
            end
            if (res_rd) begin
                checkOutput("res_addr", res_addr, issued);
                checkOutput("credit", (issued - nextBeat - int'(acc)) < 2, 1);
                checkOutput("rd_in_frame", busyExp && (issued < NPIX), 1);
                issued++;
            end
            if (streamMode && busyExp && nextBeat > 0 && nextBeat < NPIX)
                checkOutput("no_bubble", out_valid, 1);
            startAcc   = start && !busyExp;
            finishNext = acc && (nextBeat == NPIX - 1);
            if (acc && nextBeat < NPIX) begin
                if (ram[nextBeat] > maxExp) maxExp = ram[nextBeat];
                if (ram[nextBeat] != 0) fgExp++;
                nextBeat++;
            end
            busyExp = finishExp ? 1'b0 : (busyExp || startAcc);
            if (startAcc) begin
                nextBeat = 0; issued = 0; maxExp = 0; fgExp = 0;
            end
            finishExp = finishNext;
        end
    end

    task automatic waitBeat(input int target, input int budget);
        bit found = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (nextBeat >= target) begin
                found = 1;
                break;
            end
        end
        if (!found) checkOutput("timeout_beat", 0, 1);
    endtask

    task automatic waitFinish(input int budget, input bit randomReady);
        bit found = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (randomReady) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (finish) begin
                found = 1;
                break;
            end
        end
        if (!found) checkOutput("timeout_finish", 0, 1);
    endtask

    task automatic fillRamp();
        for (int i = 0; i < NPIX; i++) ram[i] = 8'(i);
    endtask

    initial begin
        bit found;
        fillRamp();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Frame 1: ramp, ready held high, restart pulse mid-frame.
        $display("[TB] frame 1: ramp, full throughput");
        streamMode = 1;
        applyStimulus(1, 1);
        applyStimulus(0, 1);
        @(negedge clk);
        checkOutput("first_rd", res_rd, 1);
        checkOutput("first_addr", res_addr, 0);
        checkOutput("valid_c1", out_valid, 0);
        @(negedge clk);
        checkOutput("valid_c2", out_valid, 0);
        @(negedge clk);
        checkOutput("valid_c3", out_valid, 1);
        checkOutput("first_data", out_data, 0);
        waitBeat(100, 400);
        start = 1;
        applyStimulus(0, 1);
        found = 0;
        for (int i = 0; i < NPIX + 100; i++) begin
            @(negedge clk);
            if (out_valid && out_ready && out_last) begin
                found = 1;
                break;
            end
        end
        checkOutput("last_seen", found, 1);
        checkOutput("last_data", out_data, 255);
        @(posedge clk);
        #1 start = 1;
        @(negedge clk);
        checkOutput("finish_next_cycle", finish, 1);
        @(posedge clk);
        #1 start = 0;
        @(negedge clk);
        checkOutput("start_in_done_ignored", busy, 0);
        checkOutput("no_rd_after_done", res_rd, 0);
        checkOutput("f1_max", max_dist, STATS_ON ? 255 : 0);
        checkOutput("f1_fg", fg_count, STATS_ON ? 16320 : 0);

        // Frame 2: sparse map, stats recomputed from zero.
        $display("[TB] frame 2: sparse map");
        for (int i = 0; i < NPIX; i++) ram[i] = 8'd0;
        ram[8000] = 8'd7;
        ram[9000] = 8'd3;
        applyStimulus(1, 1);
        applyStimulus(0, 1);
        waitFinish(NPIX + 100, 0);
        @(posedge clk);
        #1;
        checkOutput("f2_max", max_dist, STATS_ON ? 7 : 0);
        checkOutput("f2_fg", fg_count, STATS_ON ? 2 : 0);

        // Frame 3: ramp with random backpressure.
        $display("[TB] frame 3: random out_ready");
        streamMode = 0;
        fillRamp();
        applyStimulus(1, 1);
        applyStimulus(0, 1);
        waitFinish(4 * NPIX, 1);
        @(posedge clk);
        #1;
        checkOutput("f3_beats", nextBeat, NPIX);
        checkOutput("f3_max", max_dist, STATS_ON ? 255 : 0);
        checkOutput("f3_fg", fg_count, STATS_ON ? 16320 : 0);

        // Frame 4: stall after start, resume, then reset mid-frame.
        $display("[TB] frame 4: stall, resume, reset");
        for (int i = 0; i < NPIX; i++) ram[i] = 8'($urandom);
        out_ready = 1;
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        repeat (19) @(posedge clk);
        #1;
        checkOutput("stall_reads", issued, 2);
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_data", out_data, ram[0]);
        out_ready = 1;
        @(posedge clk);
        #1;
        checkOutput("resume_valid", out_valid, 1);
        checkOutput("resume_data", out_data, ram[1]);
        waitBeat(5000, 6000);
        rst = 1'b0;
        #1;
        checkOutput("async_reset", {busy, out_valid, res_rd, res_addr, finish}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Frame 5: restart after reset begins at address 0.
        $display("[TB] frame 5: restart after reset");
        streamMode = 1;
        applyStimulus(1, 1);
        applyStimulus(0, 1);
        @(negedge clk);
        checkOutput("restart_rd", res_rd, 1);
        checkOutput("restart_addr0", res_addr, 0);
        waitBeat(300, 600);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
